// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the two-requester SPI bus arbiter.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GNT_FLASH = 2'd1,
    GNT_RAM   = 2'd2,
    GAP       = 2'd3
  } arb_state_t;

  localparam logic REQ_FLASH = 1'b0;
  localparam logic REQ_RAM   = 1'b1;

  localparam int unsigned GAP_CNT_W  = 8;
  localparam int unsigned HOLD_CNT_W = 16;

endpackage

// File: rtl/spi_bus_arbiter_if.sv
// Requester-side and physical-side signals of the shared SPI bus arbiter.
interface spi_bus_arbiter_if;

  logic flash_req,  ram_req;
  logic flash_gnt,  ram_gnt;
  logic flash_clk,  flash_cs_n, flash_mosi;
  logic ram_clk,    ram_cs_n,   ram_mosi;
  logic flash_miso, ram_miso;
  logic spi_clk,    spi_mosi;
  logic spi_cs_n_flash, spi_cs_n_ram;
  logic spi_miso;
  logic timeout_err;

  modport slave (
    input  flash_req, ram_req,
    input  flash_clk, flash_cs_n, flash_mosi,
    input  ram_clk, ram_cs_n, ram_mosi,
    input  spi_miso,
    output flash_gnt, ram_gnt,
    output flash_miso, ram_miso,
    output spi_clk, spi_mosi, spi_cs_n_flash, spi_cs_n_ram,
    output timeout_err
  );

  modport master (
    output flash_req, ram_req,
    output flash_clk, flash_cs_n, flash_mosi,
    output ram_clk, ram_cs_n, ram_mosi,
    output spi_miso,
    input  flash_gnt, ram_gnt,
    input  flash_miso, ram_miso,
    input  spi_clk, spi_mosi, spi_cs_n_flash, spi_cs_n_ram,
    input  timeout_err
  );

endinterface

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one physical SPI bus between a flash and a RAM
// requester, with inter-grant gap, hold timeout and post-timeout lockout.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_bus_arbiter_if.slave   bus
);

  localparam logic [GAP_CNT_W-1:0]  GAP_LOAD  = GAP_CNT_W'(GAP_CYCLES - 1);
  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(TIMEOUT - 1);
  localparam arb_state_t            REL_STATE = (GAP_CYCLES == 0) ? IDLE : GAP;

  arb_state_t            r_state;
  logic [GAP_CNT_W-1:0]  r_gap_cnt;
  logic [HOLD_CNT_W-1:0] r_hold_cnt;
  logic                  r_last;
  logic                  r_lock_flash, r_lock_ram;
  logic                  r_flash_gnt, r_ram_gnt;
  logic                  r_timeout_err;

  logic w_flash_ok, w_ram_ok, w_pick_ram;
  logic w_own_flash, w_own_ram, w_owner_req, w_hold_done;

  assign w_flash_ok  = bus.flash_req & ~r_lock_flash;
  assign w_ram_ok    = bus.ram_req   & ~r_lock_ram;
  // On contention the requester not granted last wins.
  assign w_pick_ram  = w_ram_ok & (~w_flash_ok | (r_last == REQ_FLASH));
  assign w_own_flash = (r_state == GNT_FLASH);
  assign w_own_ram   = (r_state == GNT_RAM);
  assign w_owner_req = w_own_flash ? bus.flash_req : bus.ram_req;
  assign w_hold_done = (r_hold_cnt == HOLD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_gap_cnt     <= '0;
      r_hold_cnt    <= '0;
      r_last        <= REQ_RAM;
      r_lock_flash  <= 1'b0;
      r_lock_ram    <= 1'b0;
      r_flash_gnt   <= 1'b0;
      r_ram_gnt     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      if (!bus.flash_req) r_lock_flash <= 1'b0;
      if (!bus.ram_req)   r_lock_ram   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_flash_ok || w_ram_ok) begin
            r_hold_cnt <= '0;
            if (w_pick_ram) begin
              r_state   <= GNT_RAM;
              r_ram_gnt <= 1'b1;
              r_last    <= REQ_RAM;
            end else begin
              r_state     <= GNT_FLASH;
              r_flash_gnt <= 1'b1;
              r_last      <= REQ_FLASH;
            end
          end
        end
        GNT_FLASH, GNT_RAM: begin
          if (!w_owner_req || w_hold_done) begin
            r_state     <= REL_STATE;
            r_gap_cnt   <= GAP_LOAD;
            r_flash_gnt <= 1'b0;
            r_ram_gnt   <= 1'b0;
            // Still requesting at the hold limit: revoke and lock out.
            if (w_owner_req) begin
              r_timeout_err <= 1'b1;
              if (w_own_flash) r_lock_flash <= 1'b1;
              else             r_lock_ram   <= 1'b1;
            end
          end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_CNT_W'(1);
          end
        end
        GAP: begin
          if (r_gap_cnt == '0) r_state   <= IDLE;
          else                 r_gap_cnt <= r_gap_cnt - GAP_CNT_W'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Physical bus follows only the current owner; idle otherwise.
  assign bus.spi_clk        = (w_own_flash & bus.flash_clk)  | (w_own_ram & bus.ram_clk);
  assign bus.spi_mosi       = (w_own_flash & bus.flash_mosi) | (w_own_ram & bus.ram_mosi);
  assign bus.spi_cs_n_flash = ~w_own_flash | bus.flash_cs_n;
  assign bus.spi_cs_n_ram   = ~w_own_ram   | bus.ram_cs_n;
  assign bus.flash_miso     = w_own_flash & bus.spi_miso;
  assign bus.ram_miso       = w_own_ram   & bus.spi_miso;
  assign bus.flash_gnt      = r_flash_gnt;
  assign bus.ram_gnt        = r_ram_gnt;
  assign bus.timeout_err    = r_timeout_err;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scoreboard bench for spi_bus_arbiter: a rule-level model predicts each
// cycle's outputs into a queue; a negedge monitor pops and compares.
module tb_spi_bus_arbiter;

  localparam int unsigned GAP = 2;
  localparam int unsigned TMO = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  spi_bus_arbiter_if bus_if();

  spi_bus_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] gnt;   // {ram, flash}
    logic       tmo;
    logic [3:0] phy;   // {spi_clk, spi_mosi, cs_n_flash, cs_n_ram}
    logic [1:0] miso;  // {ram, flash}
  } exp_t;

  exp_t exp_q[$];
  int   cyc_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;

  // Reference model: owner 0 = nobody, 1 = flash, 2 = ram.
  int owner, hold, quiet, last;
  bit lock_f, lock_r, to_pend;

  task automatic chk(input string name, input int c, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, c, act, req);
    end
  endtask

  function automatic void model_reset();
    owner = 0; hold = 0; quiet = int'(GAP); last = 2;
    lock_f = 1'b0; lock_r = 1'b0; to_pend = 1'b0;
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    e.gnt  = {owner == 2, owner == 1};
    e.tmo  = to_pend;
    e.phy  = 4'b0011;
    e.miso = 2'b00;
    if (owner == 1) begin
      e.phy  = {bus_if.flash_clk, bus_if.flash_mosi, bus_if.flash_cs_n, 1'b1};
      e.miso = {1'b0, bus_if.spi_miso};
    end else if (owner == 2) begin
      e.phy  = {bus_if.ram_clk, bus_if.ram_mosi, 1'b1, bus_if.ram_cs_n};
      e.miso = {bus_if.spi_miso, 1'b0};
    end
    return e;
  endfunction

  // One clock of the arbitration rules applied to the sampled requests.
  function automatic void model_step(input logic fr, input logic rr);
    logic r, ef, er;
    to_pend = 1'b0;
    if (owner != 0) begin
      r = (owner == 1) ? fr : rr;
      if (!r) begin
        owner = 0; quiet = 0;
      end else if (hold == int'(TMO) - 1) begin
        if (owner == 1) lock_f = 1'b1; else lock_r = 1'b1;
        owner = 0; quiet = 0; to_pend = 1'b1;
      end else begin
        hold++;
      end
    end else if (quiet < int'(GAP)) begin
      quiet++;
    end else begin
      ef = fr && !lock_f;
      er = rr && !lock_r;
      if (ef && er)  owner = (last == 1) ? 2 : 1;
      else if (ef)   owner = 1;
      else if (er)   owner = 2;
      if (owner != 0) begin hold = 0; last = owner; end
    end
    if (!fr) lock_f = 1'b0;
    if (!rr) lock_r = 1'b0;
  endfunction

  task automatic cycle();
    exp_q.push_back(expect_now());
    cyc_q.push_back(cyc);
    @(posedge clk);
    model_step(bus_if.flash_req, bus_if.ram_req);
    cyc++;
    #1;
  endtask

  task automatic rand_pins();
    bus_if.flash_clk  = 1'($urandom_range(0, 1));
    bus_if.flash_mosi = 1'($urandom_range(0, 1));
    bus_if.flash_cs_n = 1'($urandom_range(0, 1));
    bus_if.ram_clk    = 1'($urandom_range(0, 1));
    bus_if.ram_mosi   = 1'($urandom_range(0, 1));
    bus_if.ram_cs_n   = 1'($urandom_range(0, 1));
    bus_if.spi_miso   = 1'($urandom_range(0, 1));
  endtask

  task automatic check_idle_now(input string tag);
    chk({tag, " gnt"},  cyc, 8'({bus_if.ram_gnt, bus_if.flash_gnt}), 8'd0);
    chk({tag, " cs_n"}, cyc, 8'({bus_if.spi_cs_n_flash, bus_if.spi_cs_n_ram}), 8'b11);
    chk({tag, " clk/mosi"}, cyc, 8'({bus_if.spi_clk, bus_if.spi_mosi}), 8'd0);
    chk({tag, " miso"}, cyc, 8'({bus_if.ram_miso, bus_if.flash_miso}), 8'd0);
    chk({tag, " timeout_err"}, cyc, 8'(bus_if.timeout_err), 8'd0);
  endtask

  initial begin : monitor
    exp_t e;
    int   c;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        chk("gnt",         c, 8'({bus_if.ram_gnt, bus_if.flash_gnt}), 8'(e.gnt));
        chk("timeout_err", c, 8'(bus_if.timeout_err), 8'(e.tmo));
        chk("phy bus",     c, 8'({bus_if.spi_clk, bus_if.spi_mosi,
                                  bus_if.spi_cs_n_flash, bus_if.spi_cs_n_ram}), 8'(e.phy));
        chk("miso",        c, 8'({bus_if.ram_miso, bus_if.flash_miso}), 8'(e.miso));
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    // Reset with active-looking requester inputs: bus must stay idle.
    bus_if.flash_req = 1'b1; bus_if.ram_req = 1'b1;
    bus_if.flash_clk = 1'b1; bus_if.flash_mosi = 1'b1; bus_if.flash_cs_n = 1'b0;
    bus_if.ram_clk   = 1'b1; bus_if.ram_mosi   = 1'b1; bus_if.ram_cs_n   = 1'b0;
    bus_if.spi_miso  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle_now("reset");

    bus_if.flash_req = 1'b0; bus_if.ram_req = 1'b0;
    bus_if.flash_cs_n = 1'b1; bus_if.ram_cs_n = 1'b1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Flash requests at cycle 10; RAM pins misbehave while flash owns the bus.
    repeat (10) begin rand_pins(); cycle(); end
    bus_if.flash_req = 1'b1;
    repeat (8) begin
      rand_pins();
      bus_if.ram_cs_n = 1'b0;
      bus_if.spi_miso = 1'b1;
      cycle();
    end
    bus_if.flash_req = 1'b0;
    repeat (6) begin rand_pins(); cycle(); end

    // Both requesters contend; each drops its request 5 cycles after grant.
    repeat (45) begin
      rand_pins();
      bus_if.flash_req = !(owner == 1 && hold == 5);
      bus_if.ram_req   = !(owner == 2 && hold == 5);
      cycle();
    end
    bus_if.flash_req = 1'b0; bus_if.ram_req = 1'b0;
    repeat (6) begin rand_pins(); cycle(); end

    // RAM holds past the limit, stays locked out until it drops and re-requests.
    bus_if.ram_req = 1'b1;
    repeat (30) begin rand_pins(); cycle(); end
    bus_if.ram_req = 1'b0;
    rand_pins(); cycle();
    bus_if.ram_req = 1'b1;
    repeat (8) begin rand_pins(); cycle(); end
    bus_if.ram_req = 1'b0;
    repeat (6) begin rand_pins(); cycle(); end

    // Random sticky requests.
    repeat (1500) begin
      rand_pins();
      if ($urandom_range(0, 9) == 0) bus_if.flash_req = ~bus_if.flash_req;
      if ($urandom_range(0, 9) == 0) bus_if.ram_req   = ~bus_if.ram_req;
      cycle();
    end
    bus_if.flash_req = 1'b0; bus_if.ram_req = 1'b0;
    repeat (20) begin rand_pins(); cycle(); end

    // Reset in the middle of a flash transfer.
    bus_if.flash_req = 1'b1;
    for (int i = 0; i < 10 && owner != 1; i++) begin rand_pins(); cycle(); end
    chk("flash owns before reset", cyc, 8'(bus_if.flash_gnt), 8'd1);
    for (int b = 0; b < 2; b++) begin
      bus_if.flash_cs_n = 1'b0; bus_if.flash_clk = 1'b0;
      bus_if.flash_mosi = 1'($urandom_range(0, 1));
      cycle();
    end
    bus_if.flash_cs_n = 1'b0; bus_if.flash_clk = 1'b1;
    #1;
    chk("third bit cs_n", cyc, 8'(bus_if.spi_cs_n_flash), 8'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check_idle_now("mid-grant reset");
    @(negedge clk);
    #1;
    chk("reset held timeout_err", cyc, 8'(bus_if.timeout_err), 8'd0);
    bus_if.flash_req = 1'b0;
    bus_if.flash_cs_n = 1'b1;
    model_reset();
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus_if.flash_req = 1'b1;
    repeat (4) begin rand_pins(); cycle(); end
    bus_if.flash_req = 1'b0;
    repeat (5) begin rand_pins(); cycle(); end

    chk("scoreboard drained", cyc, 8'(exp_q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_bus_arbiter.md
SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

Interface
REQ-001 Parameter GAP_CYCLES, default 2: minimum idle cycles, with both chip selects high, between consecutive grants.
REQ-002 Parameter TIMEOUT, default 4096: maximum cycles a single grant may be held.
REQ-003 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Ports flash_req / ram_req  input  1 each  requester wants the shared SPI bus.
REQ-006 Ports flash_gnt / ram_gnt  output  1 each  bus granted to that requester; registered.
REQ-007 Ports flash_clk, flash_cs_n, flash_mosi / ram_clk, ram_cs_n, ram_mosi  input  1 each  requester-side SPI drive.
REQ-008 Ports flash_miso / ram_miso  output  1 each  MISO returned to each requester.
REQ-009 Ports spi_clk, spi_mosi  output  1 each  shared physical SPI clock and data out.
REQ-010 Ports spi_cs_n_flash, spi_cs_n_ram  output  1 each  physical chip selects.
REQ-011 Port spi_miso  input  1  shared physical MISO.
REQ-012 Port timeout_err  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-013 The FSM SHALL have the states IDLE, GNT_FLASH, GNT_RAM and GAP.
REQ-014 In IDLE, a sampled request SHALL move the FSM to the matching GNT state, with gnt high from the next cycle (one-cycle grant latency).
REQ-015 If both requests are high in IDLE, the grant SHALL go to the requester not granted last (round-robin); after reset, flash wins.
REQ-016 At most one gnt SHALL be high in any cycle.
REQ-017 While GNT_x, spi_clk, spi_mosi and spi_cs_n_x SHALL combinationally follow x_clk, x_mosi and x_cs_n.
REQ-018 While GNT_x, x_miso SHALL equal spi_miso; the other requester's miso SHALL be 0.
REQ-019 The non-granted physical CS_N SHALL be held at 1.
REQ-020 Outside GNT states, spi_clk and spi_mosi SHALL be 0 and both CS_N SHALL be 1, regardless of requester inputs.
REQ-021 In GNT_x, x_req low SHALL drop gnt on the next cycle and move the FSM to GAP.
REQ-022 GAP SHALL last exactly GAP_CYCLES cycles (8-bit down-counter), then the FSM SHALL return to IDLE; minimum grant-to-grant spacing is GAP_CYCLES+1 idle cycles.
REQ-023 A 16-bit hold counter SHALL clear on grant entry and increment each GNT cycle.
REQ-024 When the hold counter reaches TIMEOUT-1 while req is still high, the next edge SHALL: drop gnt, force the bus idle, pulse timeout_err for 1 cycle, set a lockout flag for that requester, and enter GAP.
REQ-025 A locked-out requester SHALL NOT be granted until its req has been observed low for at least one cycle; the lockout then clears.
REQ-026 A request arriving in GAP SHALL be held pending and evaluated in IDLE, not lost.
REQ-027 A requester driving x_cs_n low without a grant SHALL have no effect on the physical bus.

Reset
REQ-028 While rst_n is low: FSM IDLE, both gnt 0, timeout_err 0, counters 0, lockouts 0, round-robin pointer set to favour flash, bus idle per REQ-020.
REQ-029 Reset asserted mid-grant SHALL force the bus idle immediately (asynchronously) and abandon the transaction without a timeout_err pulse.

Structure
REQ-030 Package spi_arb_pkg SHALL hold the state enumeration and the requester-ID constants (REQ_FLASH=0, REQ_RAM=1).
REQ-031 The block SHALL be a single module with no sub-modules; counters and FSM are inline.

Verification
REQ-032 flash_req rises at cycle 10 -> flash_gnt high at 11; bus mirrors flash pins; spi_cs_n_ram stays 1.
REQ-033 Both requests held high continuously, each dropped 5 cycles after its grant, GAP_CYCLES=2 -> grants alternate flash, ram, flash, with exactly 3 idle cycles (both CS_N high) between grants.
REQ-034 TIMEOUT=16, ram_req held high -> ram_gnt low after 16 grant cycles; one-cycle timeout_err; ram not re-granted until ram_req drops then rises again.
REQ-035 ram_cs_n driven low while flash is granted -> spi_cs_n_ram stays 1; ram_miso reads 0 while spi_miso=1.
REQ-036 rst_n pulsed low during the third SPI bit of a flash grant -> both CS_N go 1 immediately, gnt 0, no timeout_err; after release, flash_req high -> grant one cycle later.
